// File: rtl/ppu_pkg.sv
// Shared PPU definitions: decoded control bundle layout, ALU/RAM encodings
// and the all-zero bubble constant used by the pipeline registers.
package ppu_pkg;

    localparam int unsigned CTRL_W = 27;
    localparam int unsigned REG_W  = 5;

    // Bit offsets of each field inside the packed control bundle (LSB positions)
    localparam int unsigned OFF_COMB_OPFUNCT = 0;
    localparam int unsigned OFF_AUIPC        = 10;
    localparam int unsigned OFF_JALR         = 11;
    localparam int unsigned OFF_JAL          = 12;
    localparam int unsigned OFF_RAM_SE       = 13;
    localparam int unsigned OFF_RAM_RW       = 14;
    localparam int unsigned OFF_RAM_ENABLE   = 15;
    localparam int unsigned OFF_RF_ENABLE    = 16;
    localparam int unsigned OFF_LOAD         = 17;
    localparam int unsigned OFF_RAM_SIZE     = 18;
    localparam int unsigned OFF_SHIFT_IMM    = 20;
    localparam int unsigned OFF_ALU_OP       = 23;

    localparam logic [3:0] ALU_PASS = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;

    localparam logic [1:0] RAM_BYTE = 2'b00;
    localparam logic [1:0] RAM_HALF = 2'b01;
    localparam logic [1:0] RAM_WORD = 2'b10;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] shift_imm;
        logic [1:0] ram_size;
        logic       load;
        logic       rf_enable;
        logic       ram_enable;
        logic       ram_rw;
        logic       ram_se;
        logic       jal;
        logic       jalr;
        logic       auipc;
        logic [9:0] comb_opfunct;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipeline_reg_load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// read by the valid instruction currently in decode.
module load_use_detect
    import ppu_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    output logic             load_use_c
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit    = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit    = id_uses_rs2 && (id_rs2 == ex_rd);
        load_use_c = ex_valid && ex_load && (ex_rd != '0) && id_valid
                     && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decode outputs, inserts one bubble per
// load-use pair, squashes on flush and counts inserted bubbles.
module id_ex_pipeline_reg
    import ppu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  ctrl_t            id_ctrl,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             flush,
    input  logic             hold,
    output logic             ex_valid,
    output ctrl_t            ex_ctrl,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [REG_W-1:0] ex_rs1,
    output logic [REG_W-1:0] ex_rs2,
    output logic [REG_W-1:0] ex_rd,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] bubble_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic load_use_c;
    logic insert_bubble_c;
    logic capture_c;

    load_use_detect u_load_use_detect (
        .ex_valid    (ex_valid),
        .ex_load     (ex_ctrl.load),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .load_use_c  (load_use_c)
    );

    // flush beats hold; hold beats the load-use bubble
    always_comb begin
        insert_bubble_c = flush || (!hold && load_use_c);
        capture_c       = !flush && !hold && !load_use_c;
        hazard_stall    = load_use_c && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= CTRL_BUBBLE;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end else if (insert_bubble_c || (capture_c && !id_valid)) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= CTRL_BUBBLE;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end else if (capture_c) begin
            ex_valid    <= 1'b1;
            ex_ctrl     <= id_ctrl;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
        end
    end

    // Only hazard/flush bubbles count; empty decode slots do not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count <= '0;
        end else if (insert_bubble_c && (bubble_count != CNT_MAX)) begin
            bubble_count <= bubble_count + CNT_W'(1);
        end
    end

endmodule
